// File: rtl/upsample_2x2.sv
// 2x2 upsampler: each pooled input row is emitted as two output rows, either
// nearest-neighbour replicated or placed top-left with zero fill.
module upsample_2x2 #(
    parameter int unsigned R         = 10,
    parameter int unsigned W         = 8,
    parameter int unsigned ZERO_FILL = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [R/2-1:0][W-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [R-1:0][W-1:0]   m_data,
    output logic                  m_last
);

    localparam int unsigned RH = R / 2;

    typedef enum logic [1:0] {StIdle, StRow0, StRow1} state_e;

    state_e                state_q, state_d;
    logic [RH-1:0][W-1:0]  hold_q;
    logic                  run_q;
    logic                  accept;

    // run_q keeps s_ready low while in reset and until the first clock edge after release.
    assign s_ready = run_q && ((state_q == StIdle) || ((state_q == StRow1) && m_ready));
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRow0;
            StRow0: if (m_ready) state_d = StRow1;
            StRow1: begin
                if (m_ready) begin
                    state_d = accept ? StRow0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            hold_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (accept) begin
                hold_q <= s_data;
            end
        end
    end

    assign m_valid = (state_q != StIdle);
    assign m_last  = (state_q == StRow1);

    // Outputs are decoded from hold_q and state_q only, so no s_* input reaches m_*.
    always_comb begin
        m_data = '0;
        for (int c = 0; c < RH; c++) begin
            if (ZERO_FILL == 0) begin
                m_data[2*c]   = hold_q[c];
                m_data[2*c+1] = hold_q[c];
            end else if (state_q != StRow1) begin
                m_data[2*c] = hold_q[c];
            end
        end
    end

endmodule

// File: tb/tb_upsample_2x2.sv
// Bench for upsample_2x2: a replicate instance and a zero-fill instance share
// the same handshake stimulus; directed table, corner sequences, random scoreboard.
module tb_upsample_2x2;

    localparam int R = 10;
    localparam int W = 8;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  s_valid;
    logic                  m_ready;
    logic [R/2-1:0][W-1:0] s_data;

    logic                  s_ready, m_valid, m_last;
    logic [R-1:0][W-1:0]   m_data;
    logic                  s_ready_z, m_valid_z, m_last_z;
    logic [R-1:0][W-1:0]   m_data_z;

    upsample_2x2 #(.R(R), .W(W), .ZERO_FILL(0)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    upsample_2x2 #(.R(R), .W(W), .ZERO_FILL(1)) dut_z (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready_z),
        .s_data  (s_data),
        .m_valid (m_valid_z),
        .m_ready (m_ready),
        .m_data  (m_data_z),
        .m_last  (m_last_z)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [79:0] expand(input logic [39:0] d, input bit zf, input bit row);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            if (!zf || (!row && (i % 2 == 0))) r[i*8 +: 8] = d[(i/2)*8 +: 8];
        end
        return r;
    endfunction

    typedef struct {
        logic [39:0] din;
        logic [79:0] e0;   // replicate rows
        logic [79:0] ez;   // zero-fill top row
    } vec_t;

    vec_t vec [4];

    // Scoreboard for the random phase
    bit          mon_en = 1'b0;
    bit          beat   = 1'b0;
    logic [39:0] sb [$];
    int          n_in   = 0;
    int          n_out  = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (m_valid && m_ready) begin
                chk1("rand_sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    chk("rand_data", m_data, expand(sb[0], 1'b0, beat));
                    chk("rand_data_zf", m_data_z, expand(sb[0], 1'b1, beat));
                    chk1("rand_last", m_last, beat);
                    if (beat) void'(sb.pop_front());
                    beat = !beat;
                end
                n_out++;
            end
            if (s_valid && s_ready) begin
                sb.push_back(s_data);
                n_in++;
            end
        end
    end

    initial begin
        logic [31:0] r_lo, r_hi;

        vec[0] = '{40'h0504030201, 80'h05050404030302020101, 80'h00050004000300020001};
        vec[1] = '{40'hFF807F0100, 80'hFFFF80807F7F01010000, 80'h00FF0080007F00010000};
        vec[2] = '{40'hA55A3CC301, 80'hA5A55A5A3C3CC3C30101, 80'h00A5005A003C00C30001};
        vec[3] = '{40'h123456789A, 80'h12123434565678789A9A, 80'h0012003400560078009A};

        rstn    = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        #1 rstn = 1'b0;
        #2;
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_data_zf", m_data_z, '0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        settle();
        chk1("post_rst_s_ready", s_ready, 1'b1);
        chk1("post_rst_m_valid", m_valid, 1'b0);

        // Single rows from the table, m_ready held high
        for (int v = 0; v < 4; v++) begin
            tick();
            s_valid = 1'b1;
            s_data  = vec[v].din;
            m_ready = 1'b1;
            settle();
            chk1("tbl_idle_ready", s_ready, 1'b1);
            tick();
            s_valid = 1'b0;
            settle();
            chk1("tbl_r0_valid", m_valid, 1'b1);
            chk1("tbl_r0_last", m_last, 1'b0);
            chk("tbl_r0_data", m_data, vec[v].e0);
            chk("tbl_r0_data_zf", m_data_z, vec[v].ez);
            chk1("tbl_r0_ready", s_ready, 1'b0);
            tick();
            settle();
            chk1("tbl_r1_valid", m_valid, 1'b1);
            chk1("tbl_r1_last", m_last, 1'b1);
            chk1("tbl_r1_last_zf", m_last_z, 1'b1);
            chk("tbl_r1_data", m_data, vec[v].e0);
            chk("tbl_r1_data_zf", m_data_z, '0);
            chk1("tbl_r1_ready", s_ready, 1'b1);
            tick();
            settle();
            chk1("tbl_idle_valid", m_valid, 1'b0);
            chk1("tbl_idle_valid_zf", m_valid_z, 1'b0);
        end

        // Back-to-back stream of the four table rows
        tick();
        s_valid = 1'b1;
        s_data  = vec[0].din;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) s_valid = 1'b0;
            else        s_data  = vec[(k+1)/2].din;
            settle();
            chk1("str_valid", m_valid, 1'b1);
            chk1("str_last", m_last, 1'(k % 2));
            chk("str_data", m_data, vec[k/2].e0);
            chk("str_data_zf", m_data_z, (k % 2 == 0) ? vec[k/2].ez : 80'h0);
            chk1("str_s_ready", s_ready, 1'(k % 2));
        end
        tick();
        settle();
        chk1("str_end_valid", m_valid, 1'b0);

        // Backpressure in ROW0 then ROW1, with a competing input offered throughout
        tick();
        s_valid = 1'b1;
        s_data  = vec[2].din;
        m_ready = 1'b1;
        tick();
        s_data  = vec[3].din;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) m_ready = 1'b1;
            settle();
            chk1("bp_r0_valid", m_valid, 1'b1);
            chk1("bp_r0_last", m_last, 1'b0);
            chk("bp_r0_data", m_data, vec[2].e0);
            chk1("bp_r0_ready", s_ready, 1'b0);
            tick();
        end
        m_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) m_ready = 1'b1;
            settle();
            chk1("bp_r1_valid", m_valid, 1'b1);
            chk1("bp_r1_last", m_last, 1'b1);
            chk("bp_r1_data", m_data, vec[2].e0);
            chk1("bp_r1_ready", s_ready, j == 3);
            tick();
        end
        s_valid = 1'b0;
        settle();
        chk1("bp_next_last", m_last, 1'b0);
        chk("bp_next_data", m_data, vec[3].e0);
        tick();
        tick();
        settle();
        chk1("bp_end_valid", m_valid, 1'b0);

        // Reset during ROW1 with the consumer stalled
        tick();
        s_valid = 1'b1;
        s_data  = vec[1].din;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        settle();
        chk1("mid_rst_pre_last", m_last, 1'b1);
        rstn = 1'b0;
        settle();
        chk1("mid_rst_valid", m_valid, 1'b0);
        chk1("mid_rst_last", m_last, 1'b0);
        chk("mid_rst_data", m_data, '0);
        chk1("mid_rst_ready", s_ready, 1'b0);
        tick();
        tick();
        rstn    = 1'b1;
        m_ready = 1'b1;
        tick();
        settle();
        chk1("mid_rst_rel_ready", s_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk1("mid_rst_no_stale", m_valid, 1'b0);
            tick();
            settle();
        end

        // Random valid/ready against the scoreboard
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 20000 && n_in < 1000; cyc++) begin
            tick();
            r_lo    = $urandom;
            r_hi    = $urandom;
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = {r_hi[7:0], r_lo};
            m_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (6) tick();
        mon_en = 1'b0;
        chk("rand_inputs", 80'(n_in), 80'(1000));
        chk("rand_beats", 80'(n_out), 80'(2 * n_in));
        chk("rand_sb_empty", 80'(sb.size()), 80'(0));
        chk1("rand_end_idle", m_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upsample_2x2.md
UPSAMPLE_2X2 -- requirements
Module: upsample_2x2

Interface
REQ-001 The block SHALL have parameter R, default 10, meaning elements per output row; R is even and >= 2.
REQ-002 The block SHALL have parameter W, default 8, meaning bits per element, unsigned.
REQ-003 The block SHALL have parameter ZERO_FILL, default 0, meaning 0 = nearest-neighbour replicate and 1 = top-left placement with zeros elsewhere.
REQ-004 clk  input  1  clock; all flops on posedge clk.
REQ-005 rstn  input  1  reset; asynchronous assert, active-low.
REQ-006 s_valid  input  1  upstream pooled row valid.
REQ-007 s_ready  output  1  block can accept a pooled row this cycle.
REQ-008 s_data  input  [R/2-1:0][W-1:0]  pooled row; element 0 in the LSBs.
REQ-009 m_valid  output  1  upsampled row valid.
REQ-010 m_ready  input  1  downstream accepts the upsampled row.
REQ-011 m_data  output  [R-1:0][W-1:0]  upsampled row; element 0 in the LSBs.
REQ-012 m_last  output  1  high on the second (bottom) row of each 2x2 expansion.

Function
REQ-013 An input transfer SHALL occur only on a cycle with s_valid && s_ready; s_data is then latched into the hold register hold[R/2-1:0].
REQ-014 The FSM SHALL have states IDLE, ROW0 and ROW1, held in a single registered state variable.
REQ-015 State transitions SHALL be: IDLE --s_valid--> ROW0; ROW0 --m_ready--> ROW1; ROW1 --m_ready && s_valid--> ROW0 with a new hold; ROW1 --m_ready && !s_valid--> IDLE; all other cases hold the current state.
REQ-016 s_ready SHALL equal (state==IDLE) || (state==ROW1 && m_ready), so a back-to-back stream sustains one input every 2 cycles with no bubble.
REQ-017 m_valid SHALL equal (state!=IDLE), and m_last SHALL equal (state==ROW1).
REQ-018 m_valid, m_last and m_data SHALL depend only on registers; there SHALL be no combinational path from s_valid or s_data to any m_* output.
REQ-019 Latency SHALL be: a row accepted at edge N gives m_valid=1 with row 0 after edge N, and row 1 one cycle after row 0 is accepted.
REQ-020 With ZERO_FILL=0, both rows SHALL drive m_data[2c] = m_data[2c+1] = hold[c] for c in 0..R/2-1.
REQ-021 With ZERO_FILL=1, row 0 SHALL drive m_data[2c] = hold[c] and m_data[2c+1] = 0, and row 1 SHALL drive all zeros.
REQ-022 Element values SHALL be copied bit-exact, with no arithmetic, sign extension or saturation.
REQ-023 While m_valid && !m_ready, m_data and m_last SHALL hold stable and the hold register SHALL NOT change.
REQ-024 s_valid asserted while s_ready=0 SHALL NOT be captured and SHALL NOT alter any state.
REQ-025 Every accepted input SHALL produce exactly two output transfers, with m_last=0 then m_last=1, in order; no row is dropped or duplicated.
REQ-026 In IDLE, m_data SHALL show the last hold contents; its value there is don't-care to consumers.

Reset
REQ-027 On rstn=0, the block SHALL immediately and asynchronously set state=IDLE, hold=0, m_valid=0, m_last=0 and m_data=0.
REQ-028 During reset, s_ready SHALL be 0.
REQ-029 After rstn deasserts, s_ready SHALL equal 1 from the first clock edge onward.
REQ-030 Reset asserted mid-expansion (ROW0 or ROW1) SHALL abort the expansion; the pending rows are discarded and no m_valid appears until a new input is accepted.

Verification
REQ-031 Single row: R=10, ZERO_FILL=0, s_data={5,4,3,2,1}, m_ready=1 -> two beats, each m_data={5,5,4,4,3,3,2,2,1,1}, with m_last 0 then 1, then IDLE.
REQ-032 Streaming: s_valid held high with 4 distinct rows and m_ready=1 -> 8 output beats on consecutive cycles, s_ready pulsing every 2nd cycle, data order preserved.
REQ-033 Backpressure: m_ready=0 for 5 cycles in ROW0, then 3 cycles in ROW1 -> m_data and m_last stable throughout, s_ready=0 throughout, and each beat completes once m_ready=1.
REQ-034 Zero-fill: ZERO_FILL=1, s_data={0xFF,0x80,0x7F,0x01,0x00} -> row0 = {0,FF,0,80,0,7F,0,01,0,00} (pairs high-to-low) and row1 all zero.
REQ-035 Reset mid-op: rstn pulsed low during ROW1 with m_ready=0 -> m_valid drops in the same cycle, s_ready=1 after release, and the stale row is never emitted.
REQ-036 Random valid/ready with a scoreboard: 1000 rows with random W=8 data -> output beats = 2 x inputs and every beat matches the reference model.
